demux_1x4_32bit_reg: RTL

DEMUX_1X4_32BIT_REG -- requirements
Module: demux_1x4_32bit_reg

---
 rtl/demux_1x4_32bit_reg_pkg.sv | 14 +
 rtl/demux_1x4_32bit_reg_if.sv | 34 +++
 rtl/demux_slot.sv | 47 ++++
 rtl/demux_1x4_32bit_reg.sv | 70 +++++++
 4 files changed

// File: rtl/demux_1x4_32bit_reg_pkg.sv
// Shared constants for the 1-to-4 registered demux: default widths and
// the channel select encodings carried on {S1,S0}.
package demux_1x4_32bit_reg_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int NCH_DEF   = 4;
   localparam int ACC_W     = 16;

   localparam logic [1:0] CH0 = 2'b00;
   localparam logic [1:0] CH1 = 2'b01;
   localparam logic [1:0] CH2 = 2'b10;
   localparam logic [1:0] CH3 = 2'b11;

endpackage : demux_1x4_32bit_reg_pkg

// File: rtl/demux_1x4_32bit_reg_if.sv
// Bus bundle between a word sender/consumer pair (master) and the demux (slave).
// Input side: a word on D is accepted on a rising edge when in_valid and in_ready are both 1; the sender holds D/S0/S1 while in_ready is 0.
// Output side: Qk is taken on a rising edge when out_valid[k] and out_ready[k] are both 1.
interface demux_1x4_32bit_reg_if
   import demux_1x4_32bit_reg_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int NCH   = NCH_DEF
);

   logic             S0;
   logic             S1;
   logic [WIDTH-1:0] D;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] Q0;
   logic [WIDTH-1:0] Q1;
   logic [WIDTH-1:0] Q2;
   logic [WIDTH-1:0] Q3;
   logic [NCH-1:0]   out_valid;
   logic [NCH-1:0]   out_ready;
   logic [ACC_W-1:0] acc_count;

   modport master (
      output S0, S1, D, in_valid, out_ready,
      input  in_ready, Q0, Q1, Q2, Q3, out_valid, acc_count
   );

   modport slave (
      input  S0, S1, D, in_valid, out_ready,
      output in_ready, Q0, Q1, Q2, Q3, out_valid, acc_count
   );

endinterface : demux_1x4_32bit_reg_if

// File: rtl/demux_slot.sv
// One-entry holding register with valid/ready: loads on load_i, empties when
// the consumer takes it, and keeps the last word after it is consumed.
module demux_slot
   import demux_1x4_32bit_reg_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             ready_i,
   output logic             valid_o,
   output logic             can_load_o,
   output logic [WIDTH-1:0] data_o
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;

   // A load wins over a consume so a simultaneous take-and-refill leaves no bubble.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o    = valid_q;
   assign can_load_o = !valid_q | ready_i;
   assign data_o     = data_q;

endmodule : demux_slot

// File: rtl/demux_1x4_32bit_reg.sv
// Registered 1-to-4 demultiplexer: routes each accepted word to the slot
// selected by {S1,S0} and counts accepted words.
module demux_1x4_32bit_reg
   import demux_1x4_32bit_reg_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int NCH   = NCH_DEF
) (
   input logic                   clk,
   input logic                   rst,
   demux_1x4_32bit_reg_if.slave  bus
);

   logic [1:0]       sel;
   logic [NCH-1:0]   sel_oh;
   logic [NCH-1:0]   load;
   logic [NCH-1:0]   can_load;
   logic [NCH-1:0]   slot_valid;
   logic [WIDTH-1:0] slot_data [NCH];
   logic             in_ready;
   logic             accept;
   logic [ACC_W-1:0] acc_count_q, acc_count_d;

   assign sel = {bus.S1, bus.S0};

   always_comb begin
      sel_oh    = '0;
      sel_oh[0] = (sel == CH0);
      sel_oh[1] = (sel == CH1);
      sel_oh[2] = (sel == CH2);
      sel_oh[3] = (sel == CH3);
   end

   // in_ready depends only on the selected slot, never on in_valid.
   assign in_ready = |(can_load & sel_oh);
   assign accept   = bus.in_valid & in_ready;
   assign load     = sel_oh & {NCH{accept}};

   for (genvar k = 0; k < NCH; k++) begin : g_slot
      demux_slot #(.WIDTH(WIDTH)) u_slot (
         .clk        (clk),
         .rst        (rst),
         .load_i     (load[k]),
         .data_i     (bus.D),
         .ready_i    (bus.out_ready[k]),
         .valid_o    (slot_valid[k]),
         .can_load_o (can_load[k]),
         .data_o     (slot_data[k])
      );
   end

   always_comb begin
      acc_count_d = acc_count_q;
      if (accept) acc_count_d = acc_count_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) acc_count_q <= '0;
      else     acc_count_q <= acc_count_d;
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = slot_valid;
   assign bus.Q0        = slot_data[0];
   assign bus.Q1        = slot_data[1];
   assign bus.Q2        = slot_data[2];
   assign bus.Q3        = slot_data[3];
   assign bus.acc_count = acc_count_q;

endmodule : demux_1x4_32bit_reg
